// File: rtl/td_config_seq.sv
// Video decoder power-up configurator: waits after decoder reset, then writes a constant register table over I2C.
// First request POWERUP_WAIT+1 cycles after the nTDreset rising edge; a request holds address/data until wr_ready accepts it.
module td_config_seq #(
  parameter int unsigned POWERUP_WAIT = 1400000,
  parameter int unsigned RETRY_GAP    = 1000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [6:0]  DEV_ADDR     = 7'h20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nTDreset,
  output logic       wr_req,
  output logic [6:0] wr_dev,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  input  logic       wr_done,
  input  logic       wr_nack,
  output logic       busy,
  output logic       config_done,
  output logic       config_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_PWR  = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_RETRY_GAP = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [23:0] PWR_LAST = (POWERUP_WAIT == 0) ? 24'd0 : 24'(POWERUP_WAIT - 1);
  localparam logic [23:0] GAP_LAST = (RETRY_GAP == 0) ? 24'd0 : 24'(RETRY_GAP - 1);
  localparam int          RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);

  logic [2:0]    state, state_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [23:0]   cnt, cnt_nxt;
  logic          nt_q;
  logic          rise;

  // Register table: {addr, data}; entries past the listed ones fall back to {index, 0}.
  function automatic logic [15:0] rom_entry(input logic [7:0] i);
    case (i)
      8'd0:    rom_entry = 16'h0F00;
      8'd1:    rom_entry = 16'h0004;
      8'd2:    rom_entry = 16'h0457;
      8'd3:    rom_entry = 16'h1741;
      8'd4:    rom_entry = 16'h3102;
      8'd5:    rom_entry = 16'h3DA2;
      8'd6:    rom_entry = 16'h3E6A;
      8'd7:    rom_entry = 16'h3FA0;
      8'd8:    rom_entry = 16'h0E80;
      8'd9:    rom_entry = 16'h5581;
      8'd10:   rom_entry = 16'h0E00;
      8'd11:   rom_entry = 16'h3701;
      8'd12:   rom_entry = 16'h1D47;
      8'd13:   rom_entry = 16'h3A16;
      8'd14:   rom_entry = 16'h5004;
      8'd15:   rom_entry = 16'h0C37;
      default: rom_entry = {i, 8'h00};
    endcase
  endfunction

  assign wr_dev = DEV_ADDR;
  assign rise   = nTDreset & ~nt_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    cnt_nxt   = cnt;
    if (!nTDreset) begin
      // Decoder held in reset: abandon everything, including a same-cycle handshake.
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      retry_nxt = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            state_nxt = S_WAIT_PWR;
            idx_nxt   = '0;
            retry_nxt = '0;
            cnt_nxt   = '0;
          end
        end
        S_WAIT_PWR: begin
          idx_nxt = '0;
          if (cnt == PWR_LAST) begin
            state_nxt = S_ISSUE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 24'd1;
          end
        end
        S_ISSUE: begin
          if (wr_ready) state_nxt = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wr_done) begin
            if (!wr_nack) begin
              retry_nxt = '0;
              if (idx == LAST_IDX) begin
                state_nxt = S_DONE;
              end else begin
                idx_nxt   = idx + 8'd1;
                state_nxt = S_ISSUE;
              end
            end else if (retry < RETRY_LIM) begin
              retry_nxt = retry + 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_RETRY_GAP;
            end else begin
              state_nxt = S_ERROR;
            end
          end
        end
        S_RETRY_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = S_ISSUE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 24'd1;
          end
        end
        S_DONE:  state_nxt = S_DONE;
        S_ERROR: state_nxt = S_ERROR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so the I2C master sees glitch-free levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      nt_q        <= 1'b1;
      idx         <= '0;
      retry       <= '0;
      cnt         <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      busy        <= 1'b0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      nt_q        <= nTDreset;
      idx         <= idx_nxt;
      retry       <= retry_nxt;
      cnt         <= cnt_nxt;
      wr_req      <= (state_nxt == S_ISSUE);
      {wr_addr, wr_data} <= (state_nxt == S_ISSUE) ? rom_entry(idx_nxt) : 16'h0000;
      busy        <= (state_nxt inside {S_WAIT_PWR, S_ISSUE, S_WAIT_ACK, S_RETRY_GAP});
      config_done <= (state_nxt == S_DONE);
      config_err  <= (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_td_config_seq.sv
// Randomised bench for td_config_seq: an I2C master responder plus a deadline-based model checked every cycle.
module tb_td_config_seq;
  localparam int P  = 10;
  localparam int G  = 4;
  localparam int MR = 3;
  localparam int N  = 4;

  logic       clock, reset, nTDreset;
  logic       wr_req, wr_ready, wr_done, wr_nack;
  logic [6:0] wr_dev;
  logic [7:0] wr_addr, wr_data;
  logic       busy, config_done, config_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  td_config_seq #(.POWERUP_WAIT(P), .RETRY_GAP(G), .MAX_RETRY(MR), .NUM_REGS(N), .DEV_ADDR(7'h20)) dut (
    .clock(clock), .reset(reset), .nTDreset(nTDreset),
    .wr_req(wr_req), .wr_dev(wr_dev), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .config_done(config_done), .config_err(config_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [15:0] tb_rom(int i);
    case (i)
      0: return 16'h0F00;
      1: return 16'h0004;
      2: return 16'h0457;
      3: return 16'h1741;
      default: return {8'(i), 8'h00};
    endcase
  endfunction

  function automatic int idx_of(logic [7:0] a);
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      e = tb_rom(i);
      if (e[15:8] == a) return i;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a configuration run is a list of writes, each due no earlier than a deadline cycle.
  bit m_active, m_pend, m_done, m_err;
  bit m_prev_n = 1'b1;
  int m_idx, m_tries, m_req_at;
  bit exp_req, exp_busy, exp_done, exp_err;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_active = 0; m_pend = 0; m_done = 0; m_err = 0; m_prev_n = 1;
      end else begin
        if (!nTDreset) begin
          m_active = 0; m_pend = 0; m_done = 0; m_err = 0;
        end else if (!m_active && !m_done && !m_err) begin
          if (!m_prev_n) begin
            m_active = 1; m_idx = 0; m_tries = 0; m_pend = 0; m_req_at = cyc + P;
          end
        end else if (m_active) begin
          if (exp_req && wr_ready) begin
            m_pend = 1;
          end else if (m_pend && wr_done) begin
            m_pend = 0;
            if (!wr_nack) begin
              m_tries = 0;
              if (m_idx == N - 1) begin m_active = 0; m_done = 1; end
              else begin m_idx++; m_req_at = cyc; end
            end else if (m_tries < MR) begin
              m_tries++;
              m_req_at = cyc + G;
            end else begin
              m_active = 0; m_err = 1;
            end
          end
        end
        m_prev_n = nTDreset;
      end
      exp_req  = m_active && !m_pend && (cyc >= m_req_at);
      exp_busy = m_active;
      exp_done = m_done;
      exp_err  = m_err;
    end
  end

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("wr_req", wr_req, exp_req);
        chk("busy", busy, exp_busy);
        chk("config_done", config_done, exp_done);
        chk("config_err", config_err, exp_err);
        chk("wr_dev", wr_dev, 7'h20);
        if (exp_req) begin
          e = tb_rom(m_idx);
          chk("wr_addr", wr_addr, e[15:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
    end
  end

  // Responder: acts as the I2C byte master.
  int         acc_cnt[N], att[N], plan[N], req_cyc[N];
  logic [7:0] acc_log[$];
  int         done_cnt = 0, pend_idx = -1, abort_idx = -1, fixed_lat = 3, stall_left = 0;
  logic [7:0] stall_addr = 8'h00;
  bit         pend_nack = 0, aborted = 0, rand_ready = 0;

  initial begin : responder
    logic       acc;
    logic [7:0] a_addr;
    int         ri;
    wr_ready = 1'b1; wr_done = 1'b0; wr_nack = 1'b0;
    forever begin
      @(negedge clock);
      acc    = wr_req && wr_ready && !reset;
      a_addr = wr_addr;
      if (wr_req) begin
        ri = idx_of(wr_addr);
        if (ri >= 0) req_cyc[ri]++;
      end
      @(posedge clock);
      #1;
      wr_done = 1'b0; wr_nack = 1'b0;
      if (reset || !nTDreset) begin
        done_cnt = 0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          wr_done = 1'b1; wr_nack = pend_nack;
          if (pend_idx == abort_idx) begin
            nTDreset = 1'b0; aborted = 1; abort_idx = -1;
          end
        end
      end
      if (acc) begin
        ri = idx_of(a_addr);
        pend_idx = ri;
        pend_nack = 0;
        if (ri >= 0) begin
          acc_cnt[ri]++;
          pend_nack = (att[ri] < plan[ri]);
          att[ri]++;
        end
        acc_log.push_back(a_addr);
        done_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
      if (stall_left > 0 && wr_req && wr_addr == stall_addr) begin
        wr_ready = 1'b0; stall_left--;
      end else if (rand_ready) begin
        wr_ready = ($urandom_range(0, 2) != 0);
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  task automatic reset_stats();
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0; att[i] = 0; req_cyc[i] = 0;
    end
    acc_log.delete();
    aborted = 0;
  endtask

  int t_edge;
  task automatic restart();
    @(posedge clock); #1;
    nTDreset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_stats();
    nTDreset = 1'b1;
    t_edge = cyc;
  endtask

  task automatic wait_end(int maxc);
    int k = 0;
    while (!(config_done || config_err || aborted) && k < maxc) begin
      @(negedge clock);
      k++;
    end
    chk("settle_timeout", (config_done || config_err || aborted), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, n;
    bit         exp_e;
    logic [15:0] e;
    reset = 1'b1; nTDreset = 1'b1;
    for (int i = 0; i < N; i++) plan[i] = 0;
    reset_stats();
    repeat (3) @(negedge clock);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_data", {wr_addr, wr_data}, 0);
    chk("rst_done_err", {config_done, config_err}, 0);
    @(posedge clock); #1 reset = 1'b0;
    n = 0;
    repeat (20) begin @(negedge clock); if (wr_req || busy) n++; end
    chk("no_start_on_reset_release", n, 0);

    // Nominal run
    restart();
    k = 0;
    while (!wr_req && k < 60) begin @(negedge clock); k++; end
    chk("first_req_latency", cyc - t_edge, P + 1);
    wait_end(300);
    chk("nominal_done", config_done, 1);
    chk("nominal_busy", busy, 0);
    chk("nominal_writes", acc_log.size(), N);
    for (int i = 0; i < N && i < acc_log.size(); i++) begin
      e = tb_rom(i);
      chk("nominal_order", acc_log[i], e[15:8]);
    end

    // Backpressure on ROM[1]
    e = tb_rom(1);
    stall_addr = e[15:8];
    stall_left = 5;
    restart();
    wait_end(300);
    chk("bp_req_cycles", req_cyc[1], 6);
    chk("bp_accepts", acc_cnt[1], 1);
    chk("bp_done", config_done, 1);

    // Two NACKs on ROM[2]
    plan[2] = 2;
    restart();
    wait_end(400);
    chk("retry_issues", acc_cnt[2], 3);
    chk("retry_done", config_done, 1);
    chk("retry_err", config_err, 0);
    plan[2] = 0;

    // Exhausted retries on ROM[0]
    plan[0] = 9;
    restart();
    wait_end(400);
    repeat (30) @(negedge clock);
    chk("exh_err", config_err, 1);
    chk("exh_done", config_done, 0);
    chk("exh_issues", acc_cnt[0], MR + 1);
    chk("exh_next_reg", acc_cnt[1], 0);
    plan[0] = 0;

    // Abort during WAIT_ACK of ROM[1], with wr_done in the same cycle
    abort_idx = 1;
    restart();
    wait_end(300);
    chk("abort_fired", aborted, 1);
    @(negedge clock);
    chk("abort_req", wr_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", config_done, 0);
    restart();
    wait_end(300);
    e = tb_rom(0);
    chk("abort_restart_first", (acc_log.size() > 0) ? acc_log[0] : 8'hxx, e[15:8]);
    chk("abort_restart_done", config_done, 1);

    // Reset in the middle of the power-up wait
    restart();
    repeat (5) @(posedge clock);
    #3;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_outputs", {wr_req, wr_addr, wr_data, config_done, config_err}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    n = 0;
    repeat (100) begin @(negedge clock); if (wr_req || busy) n++; end
    chk("no_req_after_reset", n, 0);

    // Randomised rounds
    rand_ready = 1;
    fixed_lat  = 0;
    for (int r = 0; r < 12; r++) begin
      exp_e = 0;
      for (int i = 0; i < N; i++) begin
        k = $urandom_range(0, 9);
        plan[i] = (k < 6) ? 0 : (k < 8) ? 1 : (k < 9) ? 3 : 4;
        if (plan[i] > MR) exp_e = 1;
      end
      abort_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      restart();
      wait_end(2000);
      if (aborted) begin
        @(negedge clock);
        chk("rnd_abort_busy", busy, 0);
      end else begin
        chk("rnd_err", config_err, exp_e);
        chk("rnd_done", config_done, !exp_e);
      end
      abort_idx = -1;
      repeat (5) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td_config_seq.md
TD_CONFIG_SEQ -- requirements
Module: td_config_seq

Interface
REQ-001 Parameter POWERUP_WAIT, default 1400000; clock cycles to wait after decoder reset release before the first write (10 ms at 140 MHz).
REQ-002 Parameter RETRY_GAP, default 1000; idle cycles between a NACKed write and its retry.
REQ-003 Parameter MAX_RETRY, default 3; retries allowed per register after the first attempt.
REQ-004 Parameter NUM_REGS, default 16; entries in the internal register table, range 1..256.
REQ-005 Parameter DEV_ADDR, default 7'h20; 7-bit I2C address of the video decoder.
REQ-006 clock  in  1  sole clock; all logic rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 nTDreset  in  1  active-low decoder reset from the reset generator, synchronous to clock.
REQ-009 wr_req  out  1  write request to the I2C byte master.
REQ-010 wr_dev  out  7  device address, constant DEV_ADDR.
REQ-011 wr_addr  out  8  decoder register address.
REQ-012 wr_data  out  8  register value.
REQ-013 wr_ready  in  1  master accepts the request when wr_req and wr_ready are both high.
REQ-014 wr_done  in  1  one-cycle pulse: accepted transaction finished.
REQ-015 wr_nack  in  1  valid with wr_done; 1 = transaction NACKed.
REQ-016 busy  out  1  high in WAIT_PWR, ISSUE, WAIT_ACK and RETRY_GAP.
REQ-017 config_done  out  1  all NUM_REGS entries written and ACKed.
REQ-018 config_err  out  1  a register exhausted its retries.

Function
REQ-019 The table SHALL be an internal constant ROM of NUM_REGS {addr, data} byte pairs indexed 0..NUM_REGS-1 and written in ascending index order.
REQ-020 The FSM SHALL have states IDLE, WAIT_PWR, ISSUE, WAIT_ACK, RETRY_GAP, DONE and ERROR.
REQ-021 IDLE -> WAIT_PWR only on a nTDreset rising edge, i.e. 0 in the previous cycle and 1 now; the edge register resets to 1, so no start occurs without a low phase.
REQ-022 WAIT_PWR: clear the index, counter counts 0..POWERUP_WAIT-1, then -> ISSUE; wr_req first high exactly POWERUP_WAIT+1 cycles after the rising edge.
REQ-023 ISSUE: wr_req high, wr_addr/wr_data from ROM[index], all stable until the cycle wr_req and wr_ready are both high; then -> WAIT_ACK with wr_req low the next cycle.
REQ-024 WAIT_ACK: wr_done with wr_nack=0 -> clear the retry count; if index = NUM_REGS-1 -> DONE, otherwise increment the index and -> ISSUE.
REQ-025 WAIT_ACK: wr_done with wr_nack=1 -> if retry count < MAX_RETRY, increment it and -> RETRY_GAP; otherwise -> ERROR.
REQ-026 RETRY_GAP: count RETRY_GAP cycles, then -> ISSUE with the same index.
REQ-027 wr_done/wr_nack SHALL be ignored in every state except WAIT_ACK.
REQ-028 DONE sets config_done=1 and ERROR sets config_err=1; both are held, with no further requests.
REQ-029 nTDreset=0 in any state SHALL force IDLE next cycle: wr_req, busy, config_done and config_err to 0; the index, retry count and counters are cleared; this overrides same-cycle handshakes.
REQ-030 The counter SHALL be 24 bits; POWERUP_WAIT and RETRY_GAP above 2^24-1 are illegal.
REQ-031 The index SHALL never wrap; NUM_REGS=1 goes straight from the first ACK to DONE.

Reset
REQ-032 Asserting reset SHALL immediately put the FSM in IDLE, set the nTDreset edge register to 1, and drive wr_req=0, wr_addr=0, wr_data=0, busy=0, config_done=0 and config_err=0.
REQ-033 Deasserting reset SHALL NOT start configuration; a later nTDreset low-to-high transition does.

Verification (POWERUP_WAIT=10, RETRY_GAP=4, MAX_RETRY=3, NUM_REGS=4 unless noted)
REQ-034 Nominal: nTDreset 0->1, wr_ready=1, each wr_done ACKs 3 cycles after acceptance -> first wr_req 11 cycles after the edge, four writes of ROM[0..3] in order, config_done=1, busy=0.
REQ-035 Backpressure: wr_ready low for 5 cycles during ROM[1] -> wr_req/wr_addr/wr_data stay stable for all 5, exactly one acceptance.
REQ-036 Retry: NACK ROM[2] twice, then ACK -> two 4-cycle gaps, ROM[2] issued 3 times, config_done=1.
REQ-037 Exhaustion: NACK ROM[0] four times -> config_err=1 after the 4th NACK, no 5th request, config_done=0.
REQ-038 Abort: nTDreset low during WAIT_ACK of ROM[1] with wr_done in the same cycle -> IDLE next cycle, outputs 0; the next rising edge restarts from ROM[0].
REQ-039 Reset: assert reset mid-WAIT_PWR -> outputs 0 immediately; after release with nTDreset held 1 -> no wr_req for 100 cycles.
